// File: rtl/mem_bist_master.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bist_master
//  Purpose  : Runs one memory self-test over 32 words at byte addresses
//             64..126. Each word is written with (seed + address), read back
//             and compared. The result letter ("P" or "F") is then written to
//             the display port at 16'hFFFA, and the block parks in DONE with
//             the error summary held.
//  Ports    : clock, reset (async, active-high)
//             start, seed            - run request and pattern seed
//             mem_addr/wdata/write/read, mem_rdata - memory/IO bus
//             busy, done, pass, err_count, first_err_addr - status
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bist_master (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] seed,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_count,
    output logic [15:0] first_err_addr
);

    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_write   = 3'd1;
    localparam logic [2:0]  c_st_read    = 3'd2;
    localparam logic [2:0]  c_st_display = 3'd3;
    localparam logic [2:0]  c_st_done    = 3'd4;

    localparam logic [15:0] c_disp_addr  = 16'hFFFA;
    localparam logic [6:0]  c_seg_p      = 7'b1100111;
    localparam logic [6:0]  c_seg_f      = 7'b1000111;
    localparam logic [5:0]  c_err_max    = 6'd32;
    localparam logic [4:0]  c_idx_last   = 5'd31;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [4:0]  r_idx;
    logic [15:0] r_seed;
    logic [5:0]  r_err_count;
    logic [15:0] r_first_err_addr;
    logic        r_pass;

    logic        w_accept;
    logic [15:0] w_addr;
    logic [15:0] w_exp;
    logic        w_mismatch;

    // A(i) = 64 + 2*i: bit 6 is always set and i sits in bits 5:1.
    assign w_addr     = {9'd0, 1'b1, r_idx, 1'b0};
    assign w_exp      = r_seed + w_addr;
    assign w_mismatch = (mem_rdata != w_exp);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus decode. Bus outputs depend only on state and
    // index, never on start, so a start edge cannot glitch the bus.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        mem_addr    = 16'd0;
        mem_wdata   = 16'd0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_write;
                end
            end
            c_st_write: begin
                mem_write = 1'b1;
                mem_addr  = w_addr;
                mem_wdata = w_exp;
                if (r_idx == c_idx_last) begin
                    w_state_nxt = c_st_read;
                end
            end
            c_st_read: begin
                mem_read = 1'b1;
                mem_addr = w_addr;
                if (r_idx == c_idx_last) begin
                    w_state_nxt = c_st_display;
                end
            end
            c_st_display: begin
                mem_write   = 1'b1;
                mem_addr    = c_disp_addr;
                mem_wdata   = {9'd0, (r_err_count == 6'd0) ? c_seg_p : c_seg_f};
                w_state_nxt = c_st_done;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Index, seed and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx            <= 5'd0;
            r_seed           <= 16'd0;
            r_err_count      <= 6'd0;
            r_first_err_addr <= 16'd0;
            r_pass           <= 1'b0;
        end else if (w_accept) begin
            r_idx            <= 5'd0;
            r_seed           <= seed;
            r_err_count      <= 6'd0;
            r_first_err_addr <= 16'd0;
            r_pass           <= 1'b0;
        end else begin
            case (r_state)
                c_st_write: begin
                    // Wraps 31 -> 0 so READ starts at i=0.
                    r_idx <= r_idx + 5'd1;
                end
                c_st_read: begin
                    r_idx <= r_idx + 5'd1;
                    if (w_mismatch) begin
                        if (r_err_count != c_err_max) begin
                            r_err_count <= r_err_count + 6'd1;
                        end
                        if (r_err_count == 6'd0) begin
                            r_first_err_addr <= w_addr;
                        end
                    end
                end
                c_st_display: begin
                    r_pass <= (r_err_count == 6'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy           = (r_state == c_st_write) || (r_state == c_st_read) ||
                            (r_state == c_st_display);
    assign done           = (r_state == c_st_done);
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bist_master
//  Purpose  : Directed self-checking bench for mem_bist_master with a small
//             behavioural memory (good / stuck word / all-ones read modes).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bist_master;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] seed;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  err_count;
    logic [15:0] first_err_addr;

    int          n_vec;
    int          n_err;
    int          bus_mode;
    int          strobes;
    int          disp_cnt;
    logic [15:0] disp_data;
    logic [15:0] mem [0:63];

    mem_bist_master dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .seed           (seed),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: mode 0 good, mode 1 word 80 stuck at 0, mode 2 reads all ones.
    always_comb begin
        mem_rdata = mem[mem_addr[6:1]];
        if (bus_mode == 2) begin
            mem_rdata = 16'hFFFF;
        end else if (bus_mode == 1 && mem_addr == 16'd80) begin
            mem_rdata = 16'h0000;
        end
    end

    always @(posedge clock) begin
        if (mem_write || mem_read) strobes <= strobes + 1;
        if (mem_write && mem_addr >= 16'd64 && mem_addr <= 16'd126)
            mem[mem_addr[6:1]] <= mem_wdata;
        if (mem_write && mem_addr == 16'hFFFA) begin
            disp_cnt  <= disp_cnt + 1;
            disp_data <= mem_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mem_write && mem_read) check_val("wr_rd_exclusive", 1, 0);
    end

    // One full run; edge 0 is the accepted start edge, DONE after edge 65.
    task automatic run(input logic [15:0] s, input int exp_errs, input logic [15:0] exp_first,
                       input bit extra, input bit hold);
        logic [15:0] a;
        logic [15:0] e;
        logic [15:0] seg;
        seg = (exp_errs == 0) ? 16'h0067 : 16'h0047;
        @(negedge clock);
        seed  = s;
        start = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 65; k++) begin
            @(negedge clock);
            if (!hold) begin
                start = extra && (k == 5 || k == 40 || k == 64);
                seed  = start ? ~s : s;
            end
            if (k < 32) begin
                a = 16'(64 + 2 * k);
                e = s + a;
                check_val("write_wr", mem_write, 1);
                check_val("write_rd", mem_read, 0);
                check_val("write_addr", mem_addr, a);
                check_val("write_data", mem_wdata, e);
            end else if (k < 64) begin
                a = 16'(64 + 2 * (k - 32));
                check_val("read_wr", mem_write, 0);
                check_val("read_rd", mem_read, 1);
                check_val("read_addr", mem_addr, a);
                check_val("read_wdata", mem_wdata, 0);
            end else begin
                check_val("disp_wr", mem_write, 1);
                check_val("disp_rd", mem_read, 0);
                check_val("disp_addr", mem_addr, 16'hFFFA);
                check_val("disp_data", mem_wdata, seg);
                check_val("disp_errs", err_count, exp_errs);
            end
            check_val("run_busy", busy, 1);
            check_val("run_done", done, 0);
        end
        @(negedge clock);
        if (!hold) start = 1'b0;
        check_val("done_flag", done, 1);
        check_val("done_busy", busy, 0);
        check_val("done_pass", pass, (exp_errs == 0));
        check_val("done_errs", err_count, exp_errs);
        check_val("done_first", first_err_addr, exp_first);
        check_val("done_bus", {mem_write, mem_read, mem_addr, mem_wdata}, 0);
        check_val("disp_seen", disp_data, seg);
    endtask

    initial begin
        int snap;
        n_vec = 0; n_err = 0; bus_mode = 0; strobes = 0; disp_cnt = 0; disp_data = 16'd0;
        for (int i = 0; i < 64; i++) mem[i] = 16'd0;
        reset = 1'b1;
        start = 1'b0;
        seed  = 16'd0;
        #3;
        check_val("rst_bus", {mem_write, mem_read, mem_addr, mem_wdata}, 0);
        check_val("rst_status", {busy, done, pass, err_count, first_err_addr}, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Good memory, data equals address.
        run(16'h0000, 0, 16'd0, 0, 0);
        check_val("mem_w64", mem[32], 16'd64);
        check_val("mem_w126", mem[63], 16'd126);

        // Stuck word at 80.
        bus_mode = 1;
        run(16'h1000, 1, 16'd80, 0, 0);

        // Every read wrong: count saturates at 32.
        bus_mode = 2;
        run(16'h0000, 32, 16'd64, 0, 0);

        // Seed wrap.
        bus_mode = 0;
        run(16'hFFF0, 0, 16'd0, 0, 0);
        check_val("wrap_e0", mem[32], 16'h0030);
        check_val("wrap_e31", mem[63], 16'h006E);

        // Extra start pulses while busy are ignored.
        run(16'h0101, 0, 16'd0, 1, 0);
        snap = strobes;
        repeat (5) @(negedge clock);
        check_val("extra_done_held", done, 1);
        check_val("extra_no_rerun", strobes, snap);

        // Reset mid-run at READ i=10 (after edge 42).
        @(negedge clock);
        seed  = 16'h0000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (42) @(negedge clock);
        check_val("pre_rst_rd", mem_read, 1);
        check_val("pre_rst_addr", mem_addr, 16'd84);
        reset = 1'b1;
        #1;
        check_val("mid_rst_bus", {mem_write, mem_read, mem_addr, mem_wdata}, 0);
        check_val("mid_rst_status", {busy, done, pass, err_count, first_err_addr}, 0);
        snap = strobes;
        repeat (3) @(negedge clock);
        check_val("mid_rst_strobes", strobes, snap);
        reset = 1'b0;
        run(16'h1234, 0, 16'd0, 0, 0);

        // start held high: back-to-back runs.
        snap = disp_cnt;
        run(16'h2222, 0, 16'd0, 0, 1);
        @(negedge clock);
        check_val("b2b_relaunch_wr", mem_write, 1);
        check_val("b2b_relaunch_addr", mem_addr, 16'd64);
        check_val("b2b_relaunch_busy", busy, 1);
        start = 1'b0;
        for (int c = 0; c < 100 && !done; c++) @(negedge clock);
        check_val("b2b_done", done, 1);
        check_val("b2b_pass", pass, 1);
        check_val("b2b_disp_count", disp_cnt - snap, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bist_master.md
MEM_BIST_MASTER -- requirements
Module: mem_bist_master

Interface
REQ-001 Ports SHALL be exactly (name  direction  width  meaning), clock and reset first:
REQ-002 clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-004 start  in  1  request a test run; sampled on rising clock edge.
REQ-005 seed  in  16  pattern seed; captured on the accepted start edge.
REQ-006 mem_addr  out  16  byte address to data memory/IO bus.
REQ-007 mem_wdata  out  16  write data to bus.
REQ-008 mem_write  out  1  write strobe; the bus responder writes on the rising edge where it is 1.
REQ-009 mem_read  out  1  read enable.
REQ-010 mem_rdata  in  16  combinational read data, valid in the same cycle as mem_addr/mem_read.
REQ-011 busy  out  1  high from the first WRITE cycle through the DISPLAY cycle.
REQ-012 done  out  1  high in DONE state.
REQ-013 pass  out  1  valid while done=1; 1 when err_count==0.
REQ-014 err_count  out  6  number of mismatching words, 0..32.
REQ-015 first_err_addr  out  16  address of the first mismatch; 0 if none.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, WRITE, READ, DISPLAY, DONE.
REQ-017 In IDLE or DONE, start=1 SHALL capture seed, clear err_count/first_err_addr/pass, and enter WRITE with index i=0; start SHALL be ignored in all other states.
REQ-018 The word address SHALL be A(i)=64+2*i for i=0..31, covering 64..126; the expected data SHALL be E(i)=(seed_q + A(i)) mod 2^16.
REQ-019 WRITE SHALL last exactly 32 cycles: mem_write=1, mem_read=0, mem_addr=A(i), mem_wdata=E(i); i increments each cycle; after i=31, enter READ with i=0.
REQ-020 READ SHALL last exactly 32 cycles: mem_read=1, mem_write=0, mem_addr=A(i), mem_wdata=0; mem_rdata is compared with E(i) in the same cycle.
REQ-021 On a READ mismatch, err_count SHALL increment at that edge; if it was 0, first_err_addr SHALL load A(i); it SHALL never exceed 32 or wrap.
REQ-022 After READ i=31 (including the compare of that cycle), the FSM SHALL enter DISPLAY.
REQ-023 DISPLAY SHALL last 1 cycle: mem_write=1, mem_addr=16'hFFFA, mem_wdata={9'd0,seg}; seg=7'b1100111 ("P") if err_count==0, else 7'b1000111 ("F"); evaluate err_count including the final READ compare.
REQ-024 Next state after DISPLAY SHALL be DONE; pass SHALL register (err_count==0); done=1; results are held until the next accepted start.
REQ-025 In IDLE and DONE, mem_addr, mem_wdata, mem_write and mem_read SHALL all be 0.
REQ-026 mem_write and mem_read SHALL never be 1 in the same cycle; the bus outputs SHALL be registered or decoded only from state and index (no combinational path from start).
REQ-027 Latency: the accepted start edge is edge 0; DONE SHALL be entered at edge 65 (32 WRITE + 32 READ + 1 DISPLAY cycles), and done=1 after that edge.
REQ-028 start held high continuously SHALL launch one run, then launch a new run on the first edge in DONE.

Reset
REQ-029 While reset=1, the module SHALL be in IDLE with i=0, seed_q=0, all outputs 0 (pass=0, err_count=0, first_err_addr=0), independent of clock.
REQ-030 Reset asserted mid-run SHALL abort immediately with no further bus strobes; memory contents are left as partially written; the next run after deassertion starts from i=0.

Verification
REQ-031 Good memory model, seed=16'h0000, start pulse -> 32 writes to 64..126 with data=address, 32 reads, DISPLAY write of 16'h0067 to FFFA, done at edge 65, pass=1, err_count=0, first_err_addr=0.
REQ-032 Model with word 80 stuck at 16'h0000, seed=16'h1000 -> err_count=1, first_err_addr=80, pass=0, DISPLAY wdata=16'h0047.
REQ-033 Model returning 16'hFFFF for all reads, seed=16'h0000 -> err_count=32 (no wrap), first_err_addr=64, pass=0.
REQ-034 seed=16'hFFF0 -> E(0)=16'h0030, E(31)=16'h006E (mod 2^16 wrap checked).
REQ-035 Assert reset at READ i=10 -> all outputs 0 asynchronously, no further strobes; a new start completes a full 65-cycle run.
REQ-036 Extra start pulses during busy are ignored (one run only); start held high launches back-to-back runs; mem_write&mem_read is never 1 (assertion).
